// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display: a blanking gap, then an ON window per digit.
// New values are taken through a ready/valid handshake and shown from the next frame. Define SEG_SCAN_LZ_BLANK_EN to suppress leading zeros.
module seg_scan_ctrl #(
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  blank_mask,
    output logic        load_ready,
    output logic        frame_done,
    output logic [3:0]  digit_code,
    output logic        dp_n,
    output logic [3:0]  an_n
);
    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic {S_GAP, S_ON} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   active, pend;
    logic [3:0]    active_dp, pend_dp;
    logic          pend_full;
    logic          dark, lz_dark;
    logic          last_on, boundary, slot_load;

    assign last_on    = (state == S_ON) && (cnt == ON_LAST);
    assign boundary   = last_on && (idx == 2'd3);
    assign slot_load  = (state == S_GAP) && (cnt == '0);
    assign frame_done = boundary;
    assign load_ready = ~pend_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_GAP;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        case (state)
            S_GAP: if (cnt == GAP_LAST) begin
                state_nxt = S_ON;
                cnt_nxt   = '0;
            end
            S_ON: if (cnt == ON_LAST) begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
                idx_nxt   = idx + 2'd1;
            end
            default: begin
                state_nxt = S_GAP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A pending value only moves to the display at the frame boundary, which
    // also frees the buffer; a full buffer blocks capture on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 16'h0000;
            active_dp <= 4'h0;
            pend      <= 16'h0000;
            pend_dp   <= 4'h0;
            pend_full <= 1'b0;
        end else if (boundary && pend_full) begin
            active    <= pend;
            active_dp <= pend_dp;
            pend_full <= 1'b0;
        end else if (load_valid && !pend_full) begin
            pend      <= load_data;
            pend_dp   <= load_dp;
            pend_full <= 1'b1;
        end
    end

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A leading zero stays lit only when its decimal point is set.
    always_comb begin
        lz_dark = 1'b0;
        case (idx)
            2'd1: lz_dark = (active[15:4]  == 12'h000) && !active_dp[1];
            2'd2: lz_dark = (active[15:8]  == 8'h00)   && !active_dp[2];
            2'd3: lz_dark = (active[15:12] == 4'h0)    && !active_dp[3];
            default: lz_dark = 1'b0;
        endcase
    end
`else
    assign lz_dark = 1'b0;
`endif

    // Code, dp and blanking latch on the first gap cycle so the decoder is settled before the anode turns on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_code <= 4'h0;
            dp_n       <= 1'b1;
            dark       <= 1'b0;
        end else if (slot_load) begin
            digit_code <= active[{idx, 2'b00} +: 4];
            dp_n       <= ~active_dp[idx];
            dark       <= blank_mask[idx] | lz_dark;
        end
    end

    always_comb begin
        an_n = 4'b1111;
        if (state == S_ON && !dark) an_n[idx] = 1'b0;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (ON=4, GAP=2): a frame-position reference model checks every cycle,
// and a vector table checks the displayed digits for a set of loaded values.
module tb_seg_scan_ctrl;
    localparam int ON  = 4;
    localparam int GAP = 2;
    localparam int S   = ON + GAP;
    localparam int F   = 4 * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_dp = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        load_ready, frame_done, dp_n;
    logic [3:0]  digit_code, an_n;

    seg_scan_ctrl #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_dp(load_dp), .blank_mask(blank_mask), .load_ready(load_ready),
        .frame_done(frame_done), .digit_code(digit_code), .dp_n(dp_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame plus display/pending buffers.
    int          m_pos = 0;
    logic [15:0] m_act = 16'h0, m_pend = 16'h0;
    logic [3:0]  m_adp = 4'h0, m_pdp = 4'h0;
    logic        m_pfull = 1'b0;
    int          cur_pos = 0;
    logic        last_xfer = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model over the next rising edge.
    task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                       input logic [3:0] p, input logic [3:0] b);
        int slot, w;
        logic on, dk;
        logic [3:0] exp_an;
        @(negedge clk);
        rst = r; load_valid = v; load_data = d; load_dp = p; blank_mask = b;
        #1;
        last_xfer = 1'b0;
        if (r) begin
            m_pos = 0; m_act = 16'h0; m_adp = 4'h0; m_pfull = 1'b0;
            cur_pos = 0;
            chk("rst_an_n", 16'(an_n), 16'hF);
            chk("rst_digit_code", 16'(digit_code), 16'h0);
            chk("rst_dp_n", 16'(dp_n), 16'h1);
            chk("rst_load_ready", 16'(load_ready), 16'h1);
            chk("rst_frame_done", 16'(frame_done), 16'h0);
        end else begin
            cur_pos = m_pos;
            slot = m_pos / S;
            w    = m_pos % S;
            on   = (w >= GAP);
            dk   = b[slot];
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (slot > 0 && (m_act >> (4 * slot)) == 16'h0 && !m_adp[slot]) dk = 1'b1;
`endif
            exp_an = (on && !dk) ? ~(4'b0001 << slot) : 4'b1111;
            chk("an_n", 16'(an_n), 16'(exp_an));
            chk("frame_done", 16'(frame_done), 16'(m_pos == F - 1));
            chk("load_ready", 16'(load_ready), 16'(!m_pfull));
            if (w >= 1) begin
                chk("digit_code", 16'(digit_code), 16'(m_act[4*slot +: 4]));
                chk("dp_n", 16'(dp_n), 16'(!m_adp[slot]));
            end
            last_xfer = v && !m_pfull;
            if (m_pos == F - 1 && m_pfull) begin
                m_act = m_pend; m_adp = m_pdp; m_pfull = 1'b0;
            end else if (last_xfer) begin
                m_pend = d; m_pdp = p; m_pfull = 1'b1;
            end
            m_pos = (m_pos + 1) % F;
        end
    endtask

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][3:0] an;
        logic [3:0][3:0] code;
        logic [3:0]      dpn;
    } vec_t;

    vec_t vecs[4];
    logic [3:0] cur_blank = 4'h0;

    initial begin
        int n;
        logic rv;
        logic [15:0] rd;
        logic [3:0] rp;

        vecs[0] = '{16'h12A4, 4'b0010, 4'b0000,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h1, 4'h2, 4'hA, 4'h4}, 4'b1101};
`ifdef SEG_SCAN_LZ_BLANK_EN
        vecs[1] = '{16'h0042, 4'b0000, 4'b0100,
                    {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h4, 4'h2}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0100, 4'b0000,
                    {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {4'h0, 4'h0, 4'h0, 4'h0}, 4'b1011};
`else
        vecs[1] = '{16'h0042, 4'b0000, 4'b0100,
                    {4'b0111, 4'b1111, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h4, 4'h2}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0100, 4'b0000,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {4'h0, 4'h0, 4'h0, 4'h0}, 4'b1011};
`endif
        vecs[3] = '{16'hBEEF, 4'b1000, 4'b0001,
                    {4'b0111, 4'b1011, 4'b1101, 4'b1111}, {4'hB, 4'hE, 4'hE, 4'hF}, 4'b0111};

        // Reset, then two idle frames.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        for (int i = 0; i < 2 * F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);

        // Table: load at a frame start, check the frame where the value is displayed.
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while ((m_pfull || m_pos != 0) && n < 3 * F) begin
                cyc(1'b0, 1'b0, 16'h0, 4'h0, cur_blank);
                n++;
            end
            if (n >= 3 * F) timeout("tbl_align");
            cur_blank = vecs[k].blank;
            cyc(1'b0, 1'b1, vecs[k].data, vecs[k].dp, cur_blank);
            for (int i = 1; i < F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, cur_blank);
            for (int i = 0; i < F; i++) begin
                cyc(1'b0, 1'b0, 16'h0, 4'h0, cur_blank);
                if (cur_pos % S == GAP + 1) begin
                    chk($sformatf("tbl%0d_an_d%0d", k, cur_pos / S), 16'(an_n), 16'(vecs[k].an[cur_pos / S]));
                    chk($sformatf("tbl%0d_code_d%0d", k, cur_pos / S), 16'(digit_code), 16'(vecs[k].code[cur_pos / S]));
                    chk($sformatf("tbl%0d_dpn_d%0d", k, cur_pos / S), 16'(dp_n), 16'(vecs[k].dpn[cur_pos / S]));
                end
            end
        end
        cur_blank = 4'h0;

        // Back-to-back: 1111 accepted, 2222 held until ready returns.
        n = 0;
        last_xfer = 1'b0;
        while (!last_xfer && n < 3 * F) begin cyc(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0); n++; end
        if (!last_xfer) timeout("b2b_first");
        n = 0;
        last_xfer = 1'b0;
        while (!last_xfer && n < 3 * F) begin cyc(1'b0, 1'b1, 16'h2222, 4'h0, 4'h0); n++; end
        if (!last_xfer) timeout("b2b_second");
        chk("b2b_second_waited", 16'(n > S), 16'h1);
        for (int i = 0; i < 3 * F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);

        // Load presented on the boundary edge with the buffer empty.
        n = 0;
        while ((m_pfull || m_pos != F - 1) && n < 3 * F) begin cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0); n++; end
        if (n >= 3 * F) timeout("bnd_align");
        cyc(1'b0, 1'b1, 16'h5678, 4'b1001, 4'h0);
        for (int i = 0; i < 3 * F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);

        // Reset during digit-2 ON with a value pending.
        n = 0;
        while ((m_pfull || m_pos != 0) && n < 3 * F) begin cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0); n++; end
        cyc(1'b0, 1'b1, 16'h9ABC, 4'hF, 4'h0);
        for (int i = 1; i < F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 16'h3333, 4'h0, 4'h0);
        n = 0;
        while (m_pos != 2 * S + GAP + 1 && n < F) begin cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0); n++; end
        if (n >= F) timeout("mid_rst_align");
        chk("pre_rst_pend_full", 16'(load_ready), 16'h0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        for (int i = 0; i < 2 * F; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);

        // Random traffic: requester holds each value until accepted.
        rv = 1'b0; rd = 16'h0; rp = 4'h0;
        for (int i = 0; i < 40 * F; i++) begin
            if (m_pos == 0) cur_blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if (!rv && $urandom_range(0, 7) == 0) begin
                rv = 1'b1;
                rd = 16'($urandom);
                if ($urandom_range(0, 3) == 0) rd = rd & 16'h00FF;
                rp = 4'($urandom_range(0, 15));
            end
            cyc(1'b0, rv, rd, rp, cur_blank);
            if (last_xfer) rv = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
